// File: rtl/pc_fetch_ctrl.sv
// rtl/pc_fetch_ctrl.sv - program counter and control-flow sequencer for the 8-bit core
//
// Sequences instruction fetch: a start/halt/done run state machine, a registered
// program counter with jump / zero-conditional branch through a writable target
// LUT, and a saturating count of RUN cycles since the last start.
//
// Optional build macro: BRANCH_REL_EN
//   undefined - a LUT entry is an absolute target address
//   defined   - a LUT entry is a signed PC_W-bit offset added to the current pc
//
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous active-high reset (clears state, pc, counter, LUT)
//   start        begin execution at address 0 (from IDLE or DONE)
//   halt         decoded halt instruction, honoured in RUN
//   jump         unconditional control transfer through LUT[target_idx]
//   branch       conditional transfer, taken when zero=1
//   zero         ALU zero flag of the current instruction
//   target_idx   LUT entry selecting the jump/branch target
//   lut_wr_en    LUT write enable (any state)
//   lut_wr_idx   LUT write address
//   lut_wr_data  LUT write data
//   pc           registered instruction-memory address
//   running      high while in RUN
//   done         high while in DONE
//   cycle_count  RUN cycles since last start, saturating

module pc_fetch_ctrl #(
    parameter int PC_W      = 10,
    parameter int LUT_IDX_W = 4,
    parameter int CYC_W     = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 halt,
    input  logic                 jump,
    input  logic                 branch,
    input  logic                 zero,
    input  logic [LUT_IDX_W-1:0] target_idx,
    input  logic                 lut_wr_en,
    input  logic [LUT_IDX_W-1:0] lut_wr_idx,
    input  logic [PC_W-1:0]      lut_wr_data,
    output logic [PC_W-1:0]      pc,
    output logic                 running,
    output logic                 done,
    output logic [CYC_W-1:0]     cycle_count
);

    localparam int LUT_N = 1 << LUT_IDX_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [PC_W-1:0]    r_pc;
    logic [PC_W-1:0]    w_pc_nxt;
    logic [CYC_W-1:0]   r_cyc;
    logic [CYC_W-1:0]   w_cyc_nxt;
    logic [PC_W-1:0]    r_lut [LUT_N];
    logic [PC_W-1:0]    w_lut_rd;
    logic [PC_W-1:0]    w_target;
    logic               w_taken;

    // Combinational read: a same-cycle write to this index is not yet visible.
    assign w_lut_rd = r_lut[target_idx];

`ifdef BRANCH_REL_EN
    // Two's-complement offset; PC_W-bit addition wraps modulo 2^PC_W.
    assign w_target = r_pc + w_lut_rd;
`else
    assign w_target = w_lut_rd;
`endif

    // zero only matters for a branch; a jump overrides it.
    assign w_taken = jump | (branch & zero);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (start) w_state_nxt = ST_RUN;
            ST_RUN:  if (halt)  w_state_nxt = ST_DONE;
            ST_DONE: if (start) w_state_nxt = ST_RUN;
            default:            w_state_nxt = ST_IDLE;
        endcase
    end

    // Outputs decoded straight from the registered state
    always_comb begin
        running = 1'b0;
        done    = 1'b0;
        case (r_state)
            ST_RUN:  running = 1'b1;
            ST_DONE: done    = 1'b1;
            default: ;
        endcase
    end

    // Datapath next values: halt > jump > branch-taken > increment in RUN
    always_comb begin
        w_pc_nxt  = r_pc;
        w_cyc_nxt = r_cyc;
        case (r_state)
            ST_RUN: begin
                if (halt) begin
                    w_pc_nxt = r_pc;
                end else if (w_taken) begin
                    w_pc_nxt = w_target;
                end else begin
                    w_pc_nxt = r_pc + PC_W'(1);
                end
                // The halt cycle is still a RUN cycle and is counted.
                if (r_cyc != {CYC_W{1'b1}}) begin
                    w_cyc_nxt = r_cyc + CYC_W'(1);
                end
            end
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_pc_nxt  = '0;
                    w_cyc_nxt = '0;
                end
            end
            default: begin
                w_pc_nxt  = '0;
                w_cyc_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc  <= '0;
            r_cyc <= '0;
        end else begin
            r_pc  <= w_pc_nxt;
            r_cyc <= w_cyc_nxt;
        end
    end

    // Target LUT: cleared by reset, writable in every state.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < LUT_N; i++) begin
                r_lut[i] <= '0;
            end
        end else if (lut_wr_en) begin
            r_lut[lut_wr_idx] <= lut_wr_data;
        end
    end

    assign pc          = r_pc;
    assign cycle_count = r_cyc;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb/tb_pc_fetch_ctrl.sv - scoreboard testbench for pc_fetch_ctrl

module tb_pc_fetch_ctrl;

    localparam int PC_W      = 10;
    localparam int LUT_IDX_W = 4;
    localparam int CYC_W     = 16;

    logic                 clk;
    logic                 reset;
    logic                 start;
    logic                 halt;
    logic                 jump;
    logic                 branch;
    logic                 zero;
    logic [LUT_IDX_W-1:0] target_idx;
    logic                 lut_wr_en;
    logic [LUT_IDX_W-1:0] lut_wr_idx;
    logic [PC_W-1:0]      lut_wr_data;
    logic [PC_W-1:0]      pc;
    logic                 running;
    logic                 done;
    logic [CYC_W-1:0]     cycle_count;

    pc_fetch_ctrl #(
        .PC_W      (PC_W),
        .LUT_IDX_W (LUT_IDX_W),
        .CYC_W     (CYC_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .halt        (halt),
        .jump        (jump),
        .branch      (branch),
        .zero        (zero),
        .target_idx  (target_idx),
        .lut_wr_en   (lut_wr_en),
        .lut_wr_idx  (lut_wr_idx),
        .lut_wr_data (lut_wr_data),
        .pc          (pc),
        .running     (running),
        .done        (done),
        .cycle_count (cycle_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string            name;
        logic [PC_W-1:0]  pc;
        logic             running;
        logic             done;
        logic [CYC_W-1:0] cyc;
    } exp_t;

    exp_t sb_q[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    // Monitor: expectations are pushed just after a rising edge and popped on the
    // following falling edge, when the registered outputs are stable.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            n_assert++;
            if (pc !== e.pc) begin
                n_fail++;
                $display("FAIL %s.pc: got 0x%03h expected 0x%03h", e.name, pc, e.pc);
            end
            n_assert++;
            if (running !== e.running) begin
                n_fail++;
                $display("FAIL %s.running: got %0b expected %0b", e.name, running, e.running);
            end
            n_assert++;
            if (done !== e.done) begin
                n_fail++;
                $display("FAIL %s.done: got %0b expected %0b", e.name, done, e.done);
            end
            n_assert++;
            if (cycle_count !== e.cyc) begin
                n_fail++;
                $display("FAIL %s.cycle_count: got %0d expected %0d", e.name, cycle_count, e.cyc);
            end
        end
    end

    task automatic clr_ctrl();
        start = 0; halt = 0; jump = 0; branch = 0; zero = 0;
        target_idx = '0; lut_wr_en = 0; lut_wr_idx = '0; lut_wr_data = '0;
    endtask

    task automatic edge_exp(input string name, input logic [PC_W-1:0] p,
                            input logic r, input logic d, input logic [CYC_W-1:0] c);
        exp_t e;
        @(posedge clk);
        #1;
        e.name = name; e.pc = p; e.running = r; e.done = d; e.cyc = c;
        sb_q.push_back(e);
    endtask

    task automatic lut_write(input logic [LUT_IDX_W-1:0] idx, input logic [PC_W-1:0] val);
        lut_wr_en = 1; lut_wr_idx = idx; lut_wr_data = val;
        @(posedge clk);
        #1;
        lut_wr_en = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clr_ctrl();
        reset = 1;
        edge_exp("reset0", 10'h000, 0, 0, 0);
        edge_exp("reset1", 10'h000, 0, 0, 0);
        reset = 0;
        edge_exp("idle_hold", 10'h000, 0, 0, 0);
        jump = 1; halt = 1; branch = 1; zero = 1;
        edge_exp("idle_ignore", 10'h000, 0, 0, 0);
        clr_ctrl();

`ifdef BRANCH_REL_EN
        lut_write(4'd1, 10'h3FC);
        lut_write(4'd2, 10'h010);
        start = 1;
        edge_exp("start", 10'h000, 1, 0, 0);
        start = 0;
        jump = 1; target_idx = 4'd2;
        edge_exp("rel_fwd", 10'h010, 1, 0, 1);
        target_idx = 4'd1;
        edge_exp("rel_back", 10'h00C, 1, 0, 2);
        jump = 0; branch = 1; zero = 0;
        edge_exp("rel_br_nt", 10'h00D, 1, 0, 3);
        zero = 1;
        edge_exp("rel_br_t", 10'h009, 1, 0, 4);
        clr_ctrl();
        reset = 1;
        edge_exp("rst_mid", 10'h000, 0, 0, 0);
        reset = 0; start = 1;
        edge_exp("restart", 10'h000, 1, 0, 0);
        start = 0; jump = 1; target_idx = 4'd1;
        edge_exp("lut_clr_spin", 10'h000, 1, 0, 1);
        jump = 0;
        edge_exp("after_spin", 10'h001, 1, 0, 2);
`else
        lut_write(4'd3, 10'h040);
        lut_write(4'd2, 10'h020);
        lut_write(4'd6, 10'h007);
        lut_write(4'd7, 10'h012);
        lut_write(4'd4, 10'h3FE);

        start = 1;
        edge_exp("start", 10'h000, 1, 0, 0);
        start = 0;
        for (int i = 1; i <= 7; i++) begin
            start = (i == 3);
            edge_exp($sformatf("step%0d", i), PC_W'(i), 1, 0, CYC_W'(i));
        end
        start = 0;

        branch = 1; zero = 1; target_idx = 4'd3;
        edge_exp("br_taken", 10'h040, 1, 0, 8);
        clr_ctrl();
        jump = 1; target_idx = 4'd6;
        edge_exp("jump_back", 10'h007, 1, 0, 9);
        jump = 0; branch = 1; zero = 0; target_idx = 4'd3;
        edge_exp("br_not_taken", 10'h008, 1, 0, 10);
        jump = 1;
        edge_exp("jump_over_br", 10'h040, 1, 0, 11);
        clr_ctrl();

        jump = 1; target_idx = 4'd7;
        edge_exp("jump_012", 10'h012, 1, 0, 12);
        halt = 1; jump = 1; branch = 1; zero = 1; target_idx = 4'd3;
        edge_exp("halt_prio", 10'h012, 0, 1, 13);
        clr_ctrl();
        edge_exp("done_hold", 10'h012, 0, 1, 13);
        start = 1;
        edge_exp("restart", 10'h000, 1, 0, 0);
        start = 0;

        jump = 1; target_idx = 4'd4;
        edge_exp("jump_3fe", 10'h3FE, 1, 0, 1);
        jump = 0;
        edge_exp("pc_3ff", 10'h3FF, 1, 0, 2);
        edge_exp("pc_wrap", 10'h000, 1, 0, 3);

        lut_wr_en = 1; lut_wr_idx = 4'd2; lut_wr_data = 10'h100;
        jump = 1; target_idx = 4'd2;
        edge_exp("wr_rd_old", 10'h020, 1, 0, 4);
        lut_wr_en = 0;
        edge_exp("wr_rd_new", 10'h100, 1, 0, 5);
        clr_ctrl();

        reset = 1;
        edge_exp("rst_mid", 10'h000, 0, 0, 0);
        reset = 0; start = 1;
        edge_exp("restart2", 10'h000, 1, 0, 0);
        start = 0; jump = 1; target_idx = 4'd3;
        edge_exp("lut_cleared", 10'h000, 1, 0, 1);
        jump = 0;
        edge_exp("after_clr", 10'h001, 1, 0, 2);
`endif
        clr_ctrl();
        @(posedge clk);
        @(posedge clk);
        n_assert++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
- Program-counter and control-flow sequencer for the 8-bit core.
- Sits directly downstream of the ALU and consumes its zero flag to resolve conditional branches.
- Drives the instruction-memory address.
- Owns a small writable branch-target lookup table (LUT), a start/halt/done run state machine and a run-cycle counter.

Parameters:
- PC_W, 10, program counter width in bits (instruction memory depth 2^PC_W).
- LUT_IDX_W, 4, branch-target LUT index width (2^LUT_IDX_W entries, each PC_W bits).
- CYC_W, 16, run-cycle counter width.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  begin program execution from address 0
- halt  input  1  decoded halt instruction, valid in RUN
- jump  input  1  unconditional taken control transfer
- branch  input  1  conditional branch, taken when zero=1
- zero  input  1  ALU zero flag for the current instruction
- target_idx  input  LUT_IDX_W  LUT entry selecting the branch/jump target
- lut_wr_en  input  1  LUT write enable
- lut_wr_idx  input  LUT_IDX_W  LUT write address
- lut_wr_data  input  PC_W  LUT write data
- pc  output  PC_W  instruction-memory address (registered)
- running  output  1  high while in RUN
- done  output  1  high while in DONE
- cycle_count  output  CYC_W  RUN cycles since last start

Behaviour:
- One clock: clk. Reset is synchronous and active-high (reset). Reset has priority over every other input.
- Reset values:
  - state=IDLE, pc=0, running=0, done=0, cycle_count=0.
  - All LUT entries are cleared to 0.
- States are IDLE, RUN and DONE. running and done are decoded directly from the registered state, with no extra latency.
- IDLE:
  - pc holds 0.
  - start=1 moves to RUN on the next edge, with pc=0 and cycle_count=0.
  - halt, jump and branch are ignored.
- RUN: each edge computes next pc with priority halt > jump > branch-taken > increment.
  - halt=1: go to DONE. pc holds the halt instruction's address.
  - jump=1: pc <= LUT[target_idx].
  - branch=1 and zero=1: pc <= LUT[target_idx].
  - branch=1 and zero=0: pc <= pc+1.
  - Otherwise: pc <= pc+1.
  - Increment is modulo 2^PC_W: pc=2^PC_W-1 wraps to 0, with no error flag.
  - start is ignored while in RUN.
  - cycle_count increments once per RUN cycle, including the halt cycle. It saturates at 2^CYC_W-1.
- DONE:
  - pc and cycle_count hold; done=1.
  - start=1 goes to RUN on the next edge with pc=0 and cycle_count=0. done drops in that same edge.
- Zero flag: zero is sampled only when branch=1 in RUN. It is a combinational input, so the ALU result is resolved in the same cycle the branch is decoded.
- Branch latency: a taken transfer is visible on pc one edge after it is asserted. There are no delay slots and no bubbles.
- LUT:
  - Write is synchronous on lut_wr_en and is allowed in any state.
  - LUT reads are combinational. On a same-cycle write and read of the same index, the read returns the old entry; the new value is used from the next cycle.
- Reset mid-RUN: returns to IDLE on the next edge. LUT contents are lost.
- Simultaneous events:
  - halt+jump in the same cycle: halt wins.
  - jump+branch in the same cycle: the jump target is used, and zero is irrelevant.

Optional Feature:
- Macro: BRANCH_REL_EN.
- Defined: a LUT entry is a signed two's-complement PC_W-bit offset. A taken jump/branch sets pc <= pc + LUT[target_idx], modulo 2^PC_W. An offset of 0 holds pc, which creates a spin loop.
- Undefined: a LUT entry is an absolute target address, as described above.
- Increment, halt and the state machine are identical in both builds.

Test Plan:
- Reset, then start pulse, then 5 idle cycles -> running=1 and pc steps 0,1,2,3,4,5; cycle_count=5; done=0.
- Write LUT[3]=0x040. In RUN at pc=7, branch=1 with zero=1 -> pc=0x040 next edge. Repeat with zero=0 -> pc=8.
- In RUN, assert halt, jump and branch together at pc=0x012 -> DONE; pc stays 0x012; done=1; running=0. Then start -> pc=0, cycle_count=0, done=0.
- Run to pc=0x3FF with no control inputs -> the next pc is 0x000 and running stays 1.
- Same cycle: lut_wr_en with LUT[2]=0x100 (old value 0x020), plus jump with target_idx=2 -> pc=0x020. A second jump one cycle later -> pc=0x100.
- BRANCH_REL_EN build: LUT[1]=0x3FC (-4) and pc=0x010 with jump -> pc=0x00C. Assert reset mid-RUN -> IDLE, pc=0, and LUT[1] reads 0.
